// File: rtl/mgt_01_div_unit_xlen.sv
// MicroGT-01 divide unit: RV32M DIV/DIVU/REM/REMU via radix-2 non-restoring iteration, with kill and clock enable.
// Optional feature macro MGT01_DIV_OPERAND_REUSE_EN keeps the last result pair for repeated operands.
`timescale 1ns/1ps

package mgt_01_div_pkg;
    typedef enum logic [1:0] {
        DIV_  = 2'b00,
        DIVU_ = 2'b01,
        REM_  = 2'b10,
        REMU_ = 2'b11
    } div_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;
endpackage

module mgt_01_div_unit_xlen
    import mgt_01_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  div_ops_e        operation_i,
    input  logic            kill_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_divide_o,
    output fu_state_e       fu_state_o
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DIVIDE  = 2'd1;
    localparam logic [1:0] RESTORE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [XLEN:0]   p_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN:0]   b_reg;
    logic            is_rem_reg, neg_q_reg, neg_r_reg;
    logic [XLEN-1:0] result_reg;
    logic            zero_div_reg;

    logic            op_signed, op_rem, dvd_neg, dvs_neg;
    logic            div_zero, sgn_ovf, special, accept, reuse_hit;
    logic [XLEN-1:0] dvd_mag, special_result, reuse_result, q_final, r_final;
    logic [XLEN:0]   dvs_ext, dvs_mag, p_shift, p_step, p_fix;

    assign op_signed = (operation_i == DIV_) || (operation_i == REM_);
    assign op_rem    = (operation_i == REM_) || (operation_i == REMU_);
    assign dvd_neg   = op_signed & dividend_i[XLEN-1];
    assign dvs_neg   = op_signed & divisor_i[XLEN-1];

    // The dividend magnitude of INT_MIN is 2^(XLEN-1), which still fits XLEN unsigned bits.
    assign dvd_mag = dvd_neg ? ({XLEN{1'b0}} - dividend_i) : dividend_i;
    assign dvs_ext = {dvs_neg, divisor_i};
    assign dvs_mag = dvs_neg ? ({(XLEN+1){1'b0}} - dvs_ext) : dvs_ext;

    assign div_zero = (divisor_i == {XLEN{1'b0}});
    assign sgn_ovf  = op_signed && (dividend_i == INT_MIN) && (divisor_i == {XLEN{1'b1}});
    assign special  = div_zero || sgn_ovf;

    always_comb begin
        special_result = {XLEN{1'b0}};
        if (div_zero) begin
            special_result = op_rem ? dividend_i : {XLEN{1'b1}};
        end else begin
            special_result = op_rem ? {XLEN{1'b0}} : dividend_i;
        end
    end

    assign accept = valid_i && (state_reg == IDLE) && !kill_i;

    // One non-restoring step: the sign of the old partial remainder picks add or subtract.
    assign p_shift = {p_reg[XLEN-1:0], a_reg[XLEN-1]};
    assign p_step  = p_reg[XLEN] ? (p_shift + b_reg) : (p_shift - b_reg);
    assign p_fix   = p_reg[XLEN] ? (p_reg + b_reg) : p_reg;

    assign q_final = neg_q_reg ? ({XLEN{1'b0}} - a_reg) : a_reg;
    assign r_final = neg_r_reg ? ({XLEN{1'b0}} - p_fix[XLEN-1:0]) : p_fix[XLEN-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (special || reuse_hit) ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt_reg == CW'(XLEN-1)) begin
                    state_next = RESTORE;
                end
            end
            RESTORE: state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (kill_i) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            p_reg        <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            is_rem_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            result_reg   <= '0;
            zero_div_reg <= 1'b0;
        end else if (clk_en_i) begin
            state_reg <= state_next;
            if (kill_i) begin
                cnt_reg <= '0;
            end else if (accept) begin
                cnt_reg    <= '0;
                p_reg      <= '0;
                a_reg      <= dvd_mag;
                b_reg      <= dvs_mag;
                is_rem_reg <= op_rem;
                neg_q_reg  <= dvd_neg ^ dvs_neg;
                neg_r_reg  <= dvd_neg;
                if (special) begin
                    result_reg   <= special_result;
                    zero_div_reg <= div_zero;
                end else if (reuse_hit) begin
                    result_reg   <= reuse_result;
                    zero_div_reg <= 1'b0;
                end else begin
                    zero_div_reg <= 1'b0;
                end
            end else if (state_reg == DIVIDE) begin
                cnt_reg <= cnt_reg + 1'b1;
                p_reg   <= p_step;
                a_reg   <= {a_reg[XLEN-2:0], ~p_step[XLEN]};
            end else if (state_reg == RESTORE) begin
                p_reg      <= p_fix;
                result_reg <= is_rem_reg ? r_final : q_final;
            end
        end
    end

`ifdef MGT01_DIV_OPERAND_REUSE_EN
    logic            reuse_vld_reg, reuse_sgn_reg, cur_sgn_reg;
    logic [XLEN-1:0] reuse_dvd_reg, reuse_dvs_reg, reuse_quo_reg, reuse_rem_reg;
    logic [XLEN-1:0] cur_dvd_reg, cur_dvs_reg;

    assign reuse_hit = reuse_vld_reg && (dividend_i == reuse_dvd_reg) &&
                       (divisor_i == reuse_dvs_reg) && (op_signed == reuse_sgn_reg);
    assign reuse_result = op_rem ? reuse_rem_reg : reuse_quo_reg;

    // Raw operands are latched at accept so the entry can be tagged when the divide finishes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reuse_vld_reg <= 1'b0;
            reuse_sgn_reg <= 1'b0;
            reuse_dvd_reg <= '0;
            reuse_dvs_reg <= '0;
            reuse_quo_reg <= '0;
            reuse_rem_reg <= '0;
            cur_sgn_reg   <= 1'b0;
            cur_dvd_reg   <= '0;
            cur_dvs_reg   <= '0;
        end else if (clk_en_i) begin
            if (kill_i) begin
                reuse_vld_reg <= 1'b0;
            end else begin
                if (accept) begin
                    cur_sgn_reg <= op_signed;
                    cur_dvd_reg <= dividend_i;
                    cur_dvs_reg <= divisor_i;
                end
                if (state_reg == RESTORE) begin
                    reuse_vld_reg <= 1'b1;
                    reuse_sgn_reg <= cur_sgn_reg;
                    reuse_dvd_reg <= cur_dvd_reg;
                    reuse_dvs_reg <= cur_dvs_reg;
                    reuse_quo_reg <= q_final;
                    reuse_rem_reg <= r_final;
                end
            end
        end
    end
`else
    assign reuse_hit    = 1'b0;
    assign reuse_result = {XLEN{1'b0}};
`endif

    assign ready_o       = (state_reg == IDLE);
    assign valid_o       = (state_reg == DONE) && !kill_i;
    assign result_o      = result_reg;
    assign zero_divide_o = zero_div_reg;
    assign fu_state_o    = (state_reg == IDLE) ? FREE : BUSY;

endmodule

// File: tb/tb_mgt_01_div_unit_xlen.sv
// Randomized and directed bench for mgt_01_div_unit_xlen against a plain-arithmetic divide model.
`timescale 1ns/1ps

module tb_mgt_01_div_unit_xlen;
    import mgt_01_div_pkg::*;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            clk_en_i;
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    div_ops_e        operation_i;
    logic            kill_i;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic            zero_divide_o;
    fu_state_e       fu_state_o;

    mgt_01_div_unit_xlen #(.XLEN(XLEN)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .clk_en_i      (clk_en_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .operation_i   (operation_i),
        .kill_i        (kill_i),
        .valid_o       (valid_o),
        .result_o      (result_o),
        .zero_divide_o (zero_divide_o),
        .fu_state_o    (fu_state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Last completed full-length operation, as the reuse feature would remember it.
    bit              m_vld = 1'b0;
    bit              m_sgn = 1'b0;
    logic [XLEN-1:0] m_a = '0, m_b = '0;

    div_ops_e        r_op;
    logic [XLEN-1:0] r_a, r_b, prev_a, prev_b, res;
    int              seen;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
        end
    endtask

    // Returns {zero_divide, result}; SV division truncates toward zero like RISC-V,
    // and the 64-bit INT_MIN / -1 quotient wraps back to INT_MIN when truncated.
    function automatic logic [XLEN:0] model(input div_ops_e op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        longint sa, sb, q, r;
        bit sgn, rem;
        sgn = (op == DIV_) || (op == REM_);
        rem = (op == REM_) || (op == REMU_);
        if (b == '0) return {1'b1, (rem ? a : {XLEN{1'b1}})};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, (rem ? r[XLEN-1:0] : q[XLEN-1:0])};
    endfunction

    // gate_at >= 0 drops clk_en_i for five edges starting after that edge.
    task automatic run_op(input div_ops_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int gate_at, input string tag, output logic [XLEN-1:0] res_o);
        logic [XLEN:0] exp_v;
        bit sgn, special, hit;
        int lat, exp_lat;
        sgn     = (op == DIV_) || (op == REM_);
        exp_v   = model(op, a, b);
        special = (b == '0) || (sgn && a == INT_MIN && b == '1);
`ifdef MGT01_DIV_OPERAND_REUSE_EN
        hit = m_vld && (m_a == a) && (m_b == b) && (m_sgn == sgn);
`else
        hit = 1'b0;
`endif
        // Short-path answers are visible straight after the accept edge.
        exp_lat = (special || hit) ? 0 : (XLEN + 1 + ((gate_at >= 0) ? 5 : 0));

        @(negedge clk_i);
        valid_i = 1'b1; operation_i = op; dividend_i = a; divisor_i = b;
        check_val({tag, ".ready"}, 64'(ready_o), 64'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 200) begin
            if (gate_at >= 0 && lat == gate_at)     clk_en_i = 1'b0;
            if (gate_at >= 0 && lat == gate_at + 5) clk_en_i = 1'b1;
            if (lat == 2) begin
                valid_i     = 1'b1;
                operation_i = div_ops_e'($urandom_range(3));
                dividend_i  = $urandom;
                divisor_i   = $urandom;
            end
            if (lat == 3) valid_i = 1'b0;
            @(posedge clk_i); #1;
            lat++;
        end
        clk_en_i = 1'b1;
        valid_i  = 1'b0;
        res_o    = result_o;
        check_val({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, ".res"}, 64'(result_o), 64'(exp_v[XLEN-1:0]));
        check_val({tag, ".zd"}, 64'(zero_divide_o), 64'(exp_v[XLEN]));
        $display("[TB] %s op=%s a=%h b=%h -> res=%h zd=%0d lat=%0d", tag, op.name(), a, b,
                 result_o, zero_divide_o, lat);
        @(posedge clk_i); #1;
        check_val({tag, ".pulse"}, 64'(valid_o), 64'd0);
        check_val({tag, ".ready_back"}, 64'(ready_o), 64'd1);
        if (!special && !hit) begin
            m_vld = 1'b1; m_sgn = sgn; m_a = a; m_b = b;
        end
    endtask

    task automatic dir_op(input div_ops_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] want, input string tag);
        logic [XLEN-1:0] got;
        run_op(op, a, b, -1, tag, got);
        check_val({tag, ".const"}, 64'(got), 64'(want));
    endtask

    initial begin
        rst_n_i = 1'b0; clk_en_i = 1'b1; valid_i = 1'b0; kill_i = 1'b0;
        operation_i = DIVU_; dividend_i = '0; divisor_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst.ready", 64'(ready_o), 64'd1);
        check_val("rst.valid", 64'(valid_o), 64'd0);
        check_val("rst.result", 64'(result_o), 64'd0);
        check_val("rst.zd", 64'(zero_divide_o), 64'd0);
        check_val("rst.fu", 64'(fu_state_o), 64'(FREE));
        @(negedge clk_i);
        rst_n_i = 1'b1;

        dir_op(DIVU_, 32'd100, 32'd7, 32'd14, "divu_100_7");
        dir_op(REMU_, 32'd100, 32'd7, 32'd2, "remu_100_7");
        dir_op(DIV_, -32'sd7, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        dir_op(REM_, -32'sd7, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        dir_op(REM_, 32'd7, -32'sd2, 32'd1, "rem_7_m2");
        dir_op(DIV_, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_5_0");
        dir_op(REM_, 32'd5, 32'd0, 32'd5, "rem_5_0");
        dir_op(DIVU_, INT_MIN, 32'hFFFF_FFFF, 32'd0, "divu_min_m1");
        dir_op(DIV_, INT_MIN, 32'hFFFF_FFFF, INT_MIN, "div_min_m1");
        dir_op(REM_, INT_MIN, 32'hFFFF_FFFF, 32'd0, "rem_min_m1");
        dir_op(DIV_, 32'd1000, 32'd13, 32'd76, "div_1000_13");
        dir_op(REM_, 32'd1000, 32'd13, 32'd12, "rem_1000_13");
        dir_op(REMU_, 32'd1000, 32'd13, 32'd12, "remu_1000_13");

        // Flush mid-divide on edge 10.
        @(negedge clk_i);
        valid_i = 1'b1; operation_i = DIVU_; dividend_i = 32'd1000; divisor_i = 32'd3;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        check_val("kill.valid", 64'(valid_o), 64'd0);
        check_val("kill.ready", 64'(ready_o), 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid_o) seen++;
        end
        check_val("kill.no_valid", 64'(seen), 64'd0);
        m_vld = 1'b0;
        $display("[TB] kill DIVU 1000/3 on edge 10, valid pulses seen afterwards=%0d", seen);

        // Kill wins over a simultaneous request.
        @(negedge clk_i);
        valid_i = 1'b1; kill_i = 1'b1; operation_i = DIV_; dividend_i = 32'd9; divisor_i = 32'd2;
        @(posedge clk_i); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        check_val("kill_prio.fu", 64'(fu_state_o), 64'(FREE));
        $display("[TB] kill+valid together, fu_state=%s", fu_state_o.name());

        dir_op(DIVU_, 32'd1000, 32'd3, 32'd333, "after_kill");

        // Asynchronous reset mid-divide, checked before the next clock edge.
        @(negedge clk_i);
        valid_i = 1'b1; operation_i = DIVU_; dividend_i = 32'd12345; divisor_i = 32'd7;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        check_val("arst.ready", 64'(ready_o), 64'd1);
        check_val("arst.valid", 64'(valid_o), 64'd0);
        check_val("arst.result", 64'(result_o), 64'd0);
        check_val("arst.zd", 64'(zero_divide_o), 64'd0);
        check_val("arst.fu", 64'(fu_state_o), 64'(FREE));
        $display("[TB] async reset mid-DIVIDE, result=%h ready=%0d", result_o, ready_o);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        m_vld = 1'b0;

        run_op(DIVU_, 32'hFFFF_FFFF, 32'd1, 10, "clken_gate", res);
        check_val("clken_gate.const", 64'(res), 64'hFFFF_FFFF);

        prev_a = 32'd1; prev_b = 32'd1;
        for (int i = 0; i < 40; i++) begin
            r_op = div_ops_e'($urandom_range(3));
            case ($urandom_range(7))
                0: r_b = '0;
                1: r_b = '1;
                2: r_b = 32'($urandom_range(16));
                3: r_b = 32'($urandom_range(255)) | 32'hFFFF_FF00;
                default: r_b = $urandom;
            endcase
            case ($urandom_range(5))
                0: r_a = INT_MIN;
                1: r_a = 32'($urandom_range(1000));
                2: r_a = -32'($urandom_range(1000));
                default: r_a = $urandom;
            endcase
            if ($urandom_range(4) == 0) begin
                r_a = prev_a; r_b = prev_b;
            end
            run_op(r_op, r_a, r_b, -1, "rnd", res);
            prev_a = r_a; prev_b = r_b;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
